// File: rtl/mult_div_if.sv
// mult_div_if - handshake and operand/result bundle between the control
// unit (master) and the mult/div sequencer (slave).
interface mult_div_if;
  logic        mult_start;
  logic        div_start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  modport master (
    output mult_start, div_start, op_a, op_b,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  mult_start, div_start, op_a, op_b,
    output busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl - 32-iteration signed multiply / restoring divide sequencer
// writing the MIPS HI/LO registers.
// Optional feature macro: MULTDIV_DIV0_EN - divide by zero skips the
// iteration phase and raises div_zero with done. Without it a divide by
// zero runs the full sequence and div_zero stays 0.
module mult_div_ctrl (
  input logic       clk,
  input logic       reset,
  mult_div_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  logic [31:0] opnd_q;
  logic        isDiv_q;
  logic        negRes_q;
  logic        negA_q;
  logic        busy_q;
  logic        done_q;
  logic        divZero_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [31:0] magA;
  logic [31:0] magB;
  logic [32:0] addSum;
  logic [32:0] remShift;
  logic [32:0] remDiff;
  logic [63:0] accStep;
  logic [63:0] prodSgn;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        divByZero;
  logic [31:0] hi_d;
  logic [31:0] lo_d;

  // Operand magnitudes, one iteration step and the sign-corrected results.
  // The accumulator is shared: for multiply it is {partial product, multiplier},
  // for divide it is {remainder, dividend/quotient} shifting left.
  always_comb begin
    magA      = bus.op_a[31] ? (~bus.op_a + 32'd1) : bus.op_a;
    magB      = bus.op_b[31] ? (~bus.op_b + 32'd1) : bus.op_b;
    addSum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    remShift  = {acc_q[63:32], acc_q[31]};
    remDiff   = remShift - {1'b0, opnd_q};
    accStep   = {addSum, acc_q[31:1]};
    if (isDiv_q) begin
      if (remDiff[32])
        accStep = {remShift[31:0], acc_q[30:0], 1'b0};
      else
        accStep = {remDiff[31:0], acc_q[30:0], 1'b1};
    end
    prodSgn   = negRes_q ? (~acc_q + 64'd1) : acc_q;
    quot      = acc_q[31:0];
    rem       = acc_q[63:32];
    divByZero = isDiv_q && (opnd_q == 32'd0);
    hi_d      = prodSgn[63:32];
    lo_d      = prodSgn[31:0];
    if (isDiv_q) begin
      // With a zero divisor every trial subtraction succeeds, so the
      // remainder half ends up holding |op_a|; re-signing it yields op_a.
      hi_d = negA_q ? (~rem + 32'd1) : rem;
      if (divByZero)
        lo_d = 32'hFFFF_FFFF;
      else
        lo_d = negRes_q ? (~quot + 32'd1) : quot;
    end
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      isDiv_q   <= 1'b0;
      negRes_q  <= 1'b0;
      negA_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divZero_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.mult_start || bus.div_start) begin
            isDiv_q   <= !bus.mult_start;
            negRes_q  <= bus.op_a[31] ^ bus.op_b[31];
            negA_q    <= bus.op_a[31];
            cnt_q     <= 5'd0;
            busy_q    <= 1'b1;
            divZero_q <= 1'b0;
            state_q   <= RUN;
            if (bus.mult_start) begin
              opnd_q <= magA;
              acc_q  <= {32'd0, magB};
            end else begin
              opnd_q <= magB;
              acc_q  <= {32'd0, magA};
`ifdef MULTDIV_DIV0_EN
              if (bus.op_b == 32'd0) begin
                acc_q   <= {magA, 32'hFFFF_FFFF};
                state_q <= FIN;
              end
`endif
            end
          end
        end
        RUN: begin
          acc_q <= accStep;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31)
            state_q <= FIN;
        end
        FIN: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
`ifdef MULTDIV_DIV0_EN
          divZero_q <= divByZero;
`else
          divZero_q <= 1'b0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = divZero_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb_mult_div_ctrl - scoreboard bench for the mult/div sequencer.
module tb_mult_div_ctrl;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          doneCycle;
    string       name;
  } expect_t;

`ifdef MULTDIV_DIV0_EN
  localparam bit Div0En = 1'b1;
`else
  localparam bit Div0En = 1'b0;
`endif
  localparam int Lat    = 33;
  localparam int Div0Lat = Div0En ? 1 : Lat;

  logic    clk = 1'b0;
  logic    reset = 1'b0;
  int      cycle = 0;
  int      tests = 0;
  int      fails = 0;
  int      firstDone = 0;
  expect_t sbQ[$];

  mult_div_if bus();

  mult_div_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock and edge counter used for latency checks.
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one start pulse at the current negedge and queue its expected result.
  task automatic applyStimulus(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expHi, input logic [31:0] expLo, input bit expDz,
                               input int lat, input string name);
    expect_t e;
    e.hi = expHi; e.lo = expLo; e.dz = expDz; e.doneCycle = cycle + 1 + lat; e.name = name;
    sbQ.push_back(e);
    bus.mult_start = m; bus.div_start = d; bus.op_a = a; bus.op_b = b;
    @(posedge clk);
    @(negedge clk);
    bus.mult_start = 1'b0; bus.div_start = 1'b0;
    bus.op_a = $urandom; bus.op_b = $urandom;
  endtask

  task automatic waitDone(input int budget, input string name);
    int n = 0;
    while (!bus.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s timeout: done not seen within %0d cycles", name, budget);
    end
  endtask

  // Monitor: every done pulse pops the oldest expectation and compares.
  always @(negedge clk) begin
    if (bus.done) begin
      if (sbQ.size() == 0) begin
        checkVal("unexpected_done", 64'd1, 64'd0);
      end else begin
        expect_t e;
        e = sbQ.pop_front();
        checkVal({e.name, "_hi"}, {32'd0, bus.hi}, {32'd0, e.hi});
        checkVal({e.name, "_lo"}, {32'd0, bus.lo}, {32'd0, e.lo});
        checkVal({e.name, "_dz"}, {63'd0, bus.div_zero}, {63'd0, e.dz});
        checkVal({e.name, "_busy"}, {63'd0, bus.busy}, 64'd0);
        checkVal({e.name, "_cycle"}, 64'(cycle), 64'(e.doneCycle));
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence.
  initial begin
    bus.mult_start = 1'b0; bus.div_start = 1'b0; bus.op_a = 32'd0; bus.op_b = 32'd0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkVal("rst_hi", {32'd0, bus.hi}, 64'd0);
    checkVal("rst_lo", {32'd0, bus.lo}, 64'd0);
    checkVal("rst_busy", {63'd0, bus.busy}, 64'd0);
    checkVal("rst_done", {63'd0, bus.done}, 64'd0);
    checkVal("rst_dz", {63'd0, bus.div_zero}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    applyStimulus(1, 0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, Lat, "mul_m3x5");
    checkVal("busy_running", {63'd0, bus.busy}, 64'd1);
    waitDone(40, "mul_m3x5"); @(negedge clk);
    applyStimulus(1, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0, Lat, "mul_min_min");
    waitDone(40, "mul_min_min"); @(negedge clk);
    applyStimulus(0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, Lat, "div_m7_2");
    waitDone(40, "div_m7_2"); @(negedge clk);
    applyStimulus(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0, Lat, "div_min_m1");
    waitDone(40, "div_min_m1"); @(negedge clk);
    applyStimulus(0, 1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 0, Lat, "div_m100_7");
    waitDone(40, "div_m100_7"); @(negedge clk);
    applyStimulus(0, 1, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 0, Lat, "div_100_m7");
    waitDone(40, "div_100_m7"); @(negedge clk);

    applyStimulus(0, 1, 32'd123, 32'd0, 32'd123, 32'hFFFF_FFFF, Div0En, Div0Lat, "div0_pos");
    waitDone(40, "div0_pos"); @(negedge clk);
    applyStimulus(0, 1, 32'hFFFF_FF85, 32'd0, 32'hFFFF_FF85, 32'hFFFF_FFFF, Div0En, Div0Lat, "div0_neg");
    waitDone(40, "div0_neg"); @(negedge clk);

    applyStimulus(1, 1, 32'd6, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFE8, 0, Lat, "both_start");
    waitDone(40, "both_start"); @(negedge clk);

    applyStimulus(1, 0, 32'd7, 32'd6, 32'd0, 32'd42, 0, Lat, "ignore_busy");
    repeat (4) @(negedge clk);
    bus.mult_start = 1'b1; bus.div_start = 1'b1; bus.op_a = 32'd9; bus.op_b = 32'd3;
    @(negedge clk);
    bus.mult_start = 1'b0; bus.div_start = 1'b0;
    checkVal("ignore_hi_held", {32'd0, bus.hi}, {32'd0, 32'hFFFF_FFFF});
    checkVal("ignore_lo_held", {32'd0, bus.lo}, {32'd0, 32'hFFFF_FFE8});
    checkVal("ignore_busy_hi", {63'd0, bus.busy}, 64'd1);
    waitDone(40, "ignore_busy");

    applyStimulus(1, 0, 32'd100000, 32'd100000, 32'd2, 32'h540B_E400, 0, Lat, "b2b_first");
    waitDone(40, "b2b_first");
    firstDone = cycle;
    applyStimulus(0, 1, 32'd100, 32'd7, 32'd2, 32'd14, 0, Lat, "b2b_second");
    waitDone(40, "b2b_second");
    checkVal("b2b_spacing", 64'(cycle - firstDone), 64'd34);
    @(negedge clk);

    for (int i = 0; i < 100; i++) begin
      bus.op_a = $urandom; bus.op_b = $urandom;
      @(negedge clk);
      checkVal("hold_hi", {32'd0, bus.hi}, 64'd2);
      checkVal("hold_lo", {32'd0, bus.lo}, 64'd14);
      checkVal("hold_done", {63'd0, bus.done}, 64'd0);
    end

    bus.mult_start = 1'b1; bus.op_a = 32'd7; bus.op_b = 32'd6;
    @(posedge clk);
    @(negedge clk);
    bus.mult_start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    checkVal("midrst_hi", {32'd0, bus.hi}, 64'd0);
    checkVal("midrst_lo", {32'd0, bus.lo}, 64'd0);
    checkVal("midrst_busy", {63'd0, bus.busy}, 64'd0);
    checkVal("midrst_done", {63'd0, bus.done}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    checkVal("midrst_quiet_lo", {32'd0, bus.lo}, 64'd0);
    applyStimulus(1, 0, 32'd7, 32'd6, 32'd0, 32'd42, 0, Lat, "after_reset");
    waitDone(40, "after_reset");
    @(negedge clk);

    checkVal("sb_empty", 64'(sbQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
